// File: rtl/sign_narrow_serializer_pkg.sv
// rtl/sign_narrow_serializer_pkg.sv - shared encodings and saturation limits
// Purpose: mode and state encodings plus the signed saturation constants used
//          by the narrowing logic and the serializer FSM.
// Ports:   none (package).
package sign_narrow_serializer_pkg;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_HALF = 2'b01,
    MODE_WORD = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_e;

  // Limits are stored sign-extended to 32 bits so the narrowed value stays a
  // valid 32-bit representation of the saturated number.
  localparam logic [31:0] SAT8_MAX  = 32'h0000_007F;
  localparam logic [31:0] SAT8_MIN  = 32'hFFFF_FF80;
  localparam logic [31:0] SAT16_MAX = 32'h0000_7FFF;
  localparam logic [31:0] SAT16_MIN = 32'hFFFF_8000;

endpackage

// File: rtl/sign_narrow_serializer_if.sv
// rtl/sign_narrow_serializer_if.sv - request and byte-stream bundle
// Purpose: groups the request side (enable/start/word_in/mode/busy/done/
//          overflow) and the UART byte handshake (tx_data/tx_valid/tx_ready).
// Ports:   none; modport master drives requests and tx_ready, modport slave
//          is the serializer.
interface sign_narrow_serializer_if;

  logic        enable;
  logic        start;
  logic [31:0] word_in;
  logic [1:0]  mode;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        done;
  logic        overflow;

  modport master (
    output enable, start, word_in, mode, tx_ready,
    input  busy, tx_data, tx_valid, done, overflow
  );

  modport slave (
    input  enable, start, word_in, mode, tx_ready,
    output busy, tx_data, tx_valid, done, overflow
  );

endinterface

// File: rtl/sign_narrow.sv
// rtl/sign_narrow.sv - combinational signed narrowing with saturation
// Purpose: narrows a 32-bit value to byte/halfword/word, saturating values
//          that do not fit to the signed limits of the chosen width.
// Ports:   word_in  in  32  value to narrow
//          mode     in  2   00 byte, 01 halfword, 10/11 word
//          narrowed out 32  narrowed value, sign-extended to 32 bits
//          count    out 3   number of bytes to send (1/2/4)
//          overflow out 1   saturation applied
module sign_narrow
  import sign_narrow_serializer_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  mode,
  output logic [31:0] narrowed,
  output logic [2:0]  count,
  output logic        overflow
);

  // A value fits in N bits iff every bit from N-1 upward equals the sign bit.
  logic fits8;
  logic fits16;

  assign fits8  = (&word_in[31:7])  | ~(|word_in[31:7]);
  assign fits16 = (&word_in[31:15]) | ~(|word_in[31:15]);

  always_comb begin
    narrowed = word_in;
    count    = 3'd4;
    overflow = 1'b0;
    case (mode)
      MODE_BYTE: begin
        count = 3'd1;
        if (!fits8) begin
          overflow = 1'b1;
          narrowed = word_in[31] ? SAT8_MIN : SAT8_MAX;
        end
      end
      MODE_HALF: begin
        count = 3'd2;
        if (!fits16) begin
          overflow = 1'b1;
          narrowed = word_in[31] ? SAT16_MIN : SAT16_MAX;
        end
      end
      default: begin
        count = 3'd4;
      end
    endcase
  end

endmodule

// File: rtl/sign_narrow_serializer.sv
// rtl/sign_narrow_serializer.sv - narrows a word and streams it LSB-first
// Purpose: latches a narrowed/saturated value on start and sends 1, 2 or 4
//          bytes little-endian over a valid/ready byte handshake.
// Ports:   clock  in  1  system clock
//          reset  in  1  asynchronous active-high reset
//          bus    slave  enable/start/word_in/mode in; busy/done/overflow out;
//                        tx_data/tx_valid out, tx_ready in
module sign_narrow_serializer
  import sign_narrow_serializer_pkg::*;
(
  input logic                     clock,
  input logic                     reset,
  sign_narrow_serializer_if.slave bus
);

  state_e      state;
  logic [31:0] value;
  logic [2:0]  count;
  logic [1:0]  index;
  logic        busy_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        done_q;
  logic        overflow_q;

  logic [31:0] narrow_value;
  logic [2:0]  narrow_count;
  logic        narrow_ovf;

  sign_narrow u_narrow (
    .word_in  (bus.word_in),
    .mode     (bus.mode),
    .narrowed (narrow_value),
    .count    (narrow_count),
    .overflow (narrow_ovf)
  );

  logic       handshake;
  logic       last_byte;
  logic [1:0] index_next;

  assign handshake  = tx_valid_q & bus.tx_ready;
  assign last_byte  = ({1'b0, index} == (count - 3'd1));
  assign index_next = index + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      value      <= '0;
      count      <= '0;
      index      <= '0;
      busy_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.enable) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            value      <= narrow_value;
            count      <= narrow_count;
            index      <= '0;
            overflow_q <= narrow_ovf;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= narrow_value[7:0];
            state      <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (last_byte) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state      <= DONE;
            end else begin
              // Present the following byte on the same edge the current one
              // transfers, so a constantly ready sink takes one byte per cycle.
              index     <= index_next;
              tx_data_q <= value[{index_next, 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/sign_narrow_serializer.md
# sign_narrow_serializer

Narrows a 32-bit register value to a signed byte, halfword or full word and streams the result LSB-first to the UART transmitter over a valid/ready byte handshake. Values that do not fit the chosen width are saturated to that width's signed limits and flagged. It sits between the datapath result bus and the UART TX byte interface. Its receive-side counterpart widens narrow fields to 32 bits with sign extension.

## Interface
- No parameters; widths fixed: 32-bit word, 8-bit byte stream.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- enable  in  1  when low, all registers hold; handshakes are neither accepted nor counted.
- start  in  1  one-cycle request; sampled only in IDLE with enable high.
- word_in  in  32  value to send; latched on accepted start.
- mode  in  2  00 byte, 01 halfword, 10 word, 11 treated as word; latched with word_in.
- busy  out  1  high from the cycle after an accepted start until done.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data valid; held until transferred.
- tx_ready  in  1  transmitter accepts byte when tx_valid and tx_ready are both high on an enabled edge.
- done  out  1  one-cycle pulse after the final byte transfers.
- overflow  out  1  saturation occurred on the current or last frame; valid with done, held until next accepted start.

## Operation
- States: IDLE, SEND, DONE.
- IDLE: start&enable -> latch the narrowed value, byte count (1/2/4) and overflow; go to SEND.
- Byte mode: value fits iff word_in[31:7] are all equal. Otherwise saturate to 0x7F (word_in[31]=0) or 0x80 (word_in[31]=1) and set overflow.
- Halfword mode: value fits iff word_in[31:15] are all equal. Otherwise saturate to 0x7FFF or 0x8000 and set overflow.
- Word mode never overflows.
- SEND: tx_valid=1, tx_data = byte[index], index starting at 0 (little-endian). On each handshake, index increments. The handshake on the last byte goes to DONE with tx_valid low that same edge.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start in SEND/DONE is ignored. It is not queued.
- tx_data and tx_valid are stable while tx_valid=1 and tx_ready=0.
- enable low in any state: no state, index or output change; done stays high if already high.

## Timing
- Reset values: busy=0, tx_valid=0, tx_data=0x00, done=0, overflow=0, state IDLE, index 0.
- Reset mid-frame: outputs take their reset values asynchronously and the partial frame is abandoned.
- Accepted start at edge t: busy and tx_valid high after t, and byte 0 is presented in cycle t+1.
- Back-to-back transfers with tx_ready constantly high: N bytes take N cycles. done asserts the cycle after the last handshake.
- Minimum start-to-start spacing is N+2 cycles, since the next start is accepted in IDLE following DONE.
- overflow updates on the start-accept edge.

## Structure
- Shared package: mode encodings (MODE_BYTE, MODE_HALF, MODE_WORD), state encoding, and saturation constants SAT8_MAX/MIN and SAT16_MAX/MIN.
- One combinational sub-module, sign_narrow: takes word_in and mode; produces the 32-bit narrowed/saturated value, byte count and overflow. It is reusable by store-halfword/byte paths.
- Top level holds the FSM, latched value, index counter and output registers.

## Test plan
- word_in=0xFFFFFF85, mode=00, tx_ready=1 -> single byte 0x85, overflow=0, done 1 cycle later.
- word_in=0x00001234, mode=01 -> bytes 0x34, 0x12; overflow=0. word_in=0x00012345, mode=01 -> 0xFF, 0x7F, overflow=1. word_in=0x80000000, mode=00 -> 0x80, overflow=1.
- word_in=0xDEADBEEF, mode=10, tx_ready toggling 1,0,0,1,... -> EF, BE, AD, DE; each byte held unchanged while tx_ready=0; exactly 4 handshakes.
- start pulsed again during SEND with word_in=0x11111111 -> ignored; the original frame completes unaltered.
- enable=0 for 3 cycles mid-frame with tx_ready=1 -> no index advance and outputs frozen; the frame resumes after enable returns.
- Reset asserted after 2 of 4 bytes -> all outputs 0 immediately; a subsequent start with 0xCAFEF00D, mode=10 sends 0D, F0, FE, CA.
